// File: rtl/gslcd_fb_rd_responder.sv
// AXI4 read-only responder that returns a framebuffer test pattern: each beat's
// data is its byte address XOR a seed, with configurable AR latency and beat gaps.
module gslcd_fb_rd_responder #(
    parameter int          C_S_AXI_ID_WIDTH   = 1,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] C_PATTERN_SEED     = 32'h0000_0000,
    parameter int          C_AR_LATENCY       = 1,
    parameter int          C_BEAT_GAP         = 0
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   s00_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [7:0]                    s00_axi_arlen,
    input  logic [2:0]                    s00_axi_arsize,
    input  logic [1:0]                    s00_axi_arburst,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]   s00_axi_rid,
    output logic [31:0]                   s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rlast,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready,
    output logic [31:0]                   beat_count
);

    typedef enum logic [1:0] {S_IDLE, S_LAT, S_BEAT, S_GAP} state_t;

    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_STEP = C_S_AXI_ADDR_WIDTH'(4);
    localparam logic [3:0] LAT_LOAD = 4'(C_AR_LATENCY - 1);
    localparam logic [3:0] GAP_LOAD = 4'(C_BEAT_GAP - 1);

    state_t                          state, state_nxt;
    logic                            rdy_en;
    logic [C_S_AXI_ID_WIDTH-1:0]     id_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]                      len_q;
    logic [7:0]                      idx_q;
    logic                            fixed_q;
    logic                            err_q;
    logic [3:0]                      cnt_q;
    logic                            ar_hs, r_hs, last_beat;

    assign ar_hs     = s00_axi_arvalid & s00_axi_arready;
    assign r_hs      = s00_axi_rvalid & s00_axi_rready;
    assign last_beat = (idx_q == len_q);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) state <= S_IDLE;
        else                  state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (ar_hs) state_nxt = S_LAT;
            S_LAT:  if (cnt_q == 4'd0) state_nxt = S_BEAT;
            S_BEAT: if (r_hs) begin
                if (last_beat)          state_nxt = S_IDLE;
                else if (C_BEAT_GAP > 0) state_nxt = S_GAP;
                else                    state_nxt = S_BEAT;
            end
            S_GAP:  if (cnt_q == 4'd0) state_nxt = S_BEAT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are gated by rvalid so they read as zero outside a beat and during reset.
    always_comb begin
        s00_axi_arready = (state == S_IDLE) && rdy_en;
        s00_axi_rvalid  = (state == S_BEAT);
        s00_axi_rlast   = s00_axi_rvalid && last_beat;
        s00_axi_rresp   = (s00_axi_rvalid && err_q) ? 2'b10 : 2'b00;
        s00_axi_rdata   = (s00_axi_rvalid && !err_q) ? (32'(addr_q) ^ C_PATTERN_SEED) : 32'h0;
        s00_axi_rid     = id_q;
    end

    // arready is held off until the first edge after reset release.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) rdy_en <= 1'b0;
        else                  rdy_en <= 1'b1;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                S_IDLE: if (ar_hs) begin
                    id_q    <= s00_axi_arid;
                    addr_q  <= s00_axi_araddr;
                    len_q   <= s00_axi_arlen;
                    idx_q   <= '0;
                    fixed_q <= (s00_axi_arburst == 2'b00);
                    err_q   <= (s00_axi_arsize != 3'b010) || s00_axi_arburst[1];
                    cnt_q   <= LAT_LOAD;
                end
                S_LAT, S_GAP: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                S_BEAT: if (r_hs) begin
                    idx_q <= idx_q + 8'd1;
                    if (!fixed_q) addr_q <= addr_q + ADDR_STEP;
                    if (C_BEAT_GAP > 0) cnt_q <= GAP_LOAD;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) beat_count <= '0;
        else if (r_hs)        beat_count <= beat_count + 32'd1;
    end

endmodule

// File: tb/tb_gslcd_fb_rd_responder.sv
// Drives two responders (slow/gapped with all-ones seed, and defaults) with shared
// AR payloads and checks every cycle against a transaction-level expectation queue.
module tb_gslcd_fb_rd_responder;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } beat_t;

    function automatic int lat_of(int g);  return (g == 0) ? 3 : 1; endfunction
    function automatic int gap_of(int g);  return (g == 0) ? 2 : 0; endfunction
    function automatic logic [31:0] seed_of(int g);
        return (g == 0) ? 32'hFFFF_FFFF : 32'h0;
    endfunction

    logic             clk = 1'b0;
    logic             rst_n;
    logic             arid;
    logic [31:0]      araddr;
    logic [7:0]       arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic [1:0]       arvalid, arready, rvalid, rlast, rid;
    logic             rready;
    logic [1:0][31:0] rdata, beat_count;
    logic [1:0][1:0]  rresp;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        gslcd_fb_rd_responder #(
            .C_S_AXI_ID_WIDTH  (1),
            .C_S_AXI_ADDR_WIDTH(32),
            .C_S_AXI_DATA_WIDTH(32),
            .C_PATTERN_SEED    ((g == 0) ? 32'hFFFF_FFFF : 32'h0),
            .C_AR_LATENCY      ((g == 0) ? 3 : 1),
            .C_BEAT_GAP        ((g == 0) ? 2 : 0)
        ) u_dut (
            .s00_axi_aclk   (clk),
            .s00_axi_aresetn(rst_n),
            .s00_axi_arid   (arid),
            .s00_axi_araddr (araddr),
            .s00_axi_arlen  (arlen),
            .s00_axi_arsize (arsize),
            .s00_axi_arburst(arburst),
            .s00_axi_arvalid(arvalid[g]),
            .s00_axi_arready(arready[g]),
            .s00_axi_rid    (rid[g]),
            .s00_axi_rdata  (rdata[g]),
            .s00_axi_rresp  (rresp[g]),
            .s00_axi_rlast  (rlast[g]),
            .s00_axi_rvalid (rvalid[g]),
            .s00_axi_rready (rready),
            .beat_count     (beat_count[g])
        );
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h exp %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: expected beats per outstanding burst plus the cycle the next beat is due.
    beat_t exp_q [2][$];
    bit    busy [2];
    int    next_vld [2];
    int    last_prog [2];
    int    mcount [2];
    int    cyc = 0;
    logic  rdy_en_m;
    beat_t b;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en_m <= 1'b0;
        else        rdy_en_m <= 1'b1;
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                chk("rst_rvalid",  32'(rvalid[g]), 0);
                chk("rst_arready", 32'(arready[g]), 0);
                chk("rst_rlast",   32'(rlast[g]), 0);
                chk("rst_rresp",   32'(rresp[g]), 0);
                chk("rst_rdata",   rdata[g], 0);
                chk("rst_rid",     32'(rid[g]), 0);
                chk("rst_count",   beat_count[g], 0);
                exp_q[g].delete();
                busy[g]   = 0;
                mcount[g] = 0;
            end else begin
                logic ev;
                ev = busy[g] && (cyc >= next_vld[g]);
                chk("arready",    32'(arready[g]), 32'(!busy[g] && rdy_en_m));
                chk("rvalid",     32'(rvalid[g]), 32'(ev));
                chk("beat_count", beat_count[g], 32'(mcount[g]));
                if (ev && rvalid[g]) begin
                    b = exp_q[g][0];
                    chk("rdata", rdata[g], b.data);
                    chk("rresp", 32'(rresp[g]), 32'(b.resp));
                    chk("rlast", 32'(rlast[g]), 32'(b.last));
                    chk("rid",   32'(rid[g]), 32'(b.id));
                end
                if (ev && rready) begin
                    b = exp_q[g].pop_front();
                    mcount[g]++;
                    last_prog[g] = cyc;
                    if (b.last) busy[g] = 0;
                    else        next_vld[g] = cyc + 1 + gap_of(g);
                end
                if (busy[g] && (cyc - last_prog[g] > 300)) begin
                    chk("timeout", 1, 0);
                    busy[g] = 0;
                    exp_q[g].delete();
                end
                if (arvalid[g] && !busy[g] && rdy_en_m) begin
                    bit          err;
                    logic [31:0] a;
                    err = (arsize != 3'd2) || (arburst >= 2'd2);
                    for (int i = 0; i <= int'(arlen); i++) begin
                        a = (arburst == 2'b01) ? araddr + 32'(4 * i) : araddr;
                        b.data = err ? 32'h0 : (a ^ seed_of(g));
                        b.resp = err ? 2'b10 : 2'b00;
                        b.last = (i == int'(arlen));
                        b.id   = arid;
                        exp_q[g].push_back(b);
                    end
                    busy[g]      = 1;
                    next_vld[g]  = cyc + 1 + lat_of(g);
                    last_prog[g] = cyc;
                end
            end
        end
    end

    bit rnd_rdy = 0;

    task automatic issue(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 2'b11;
        for (int n = 0; n < 50 && arvalid != 2'b00; n++) begin
            logic [1:0] acc;
            @(negedge clk);
            acc = arvalid & arready;
            @(posedge clk); #1;
            arvalid = arvalid & ~acc;
            rready = rnd_rdy ? 1'($urandom) : 1'b1;
        end
        arvalid = 2'b00;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 3000 && (busy[0] || busy[1]); n++) begin
            @(posedge clk); #1;
            rready = rnd_rdy ? 1'($urandom) : 1'b1;
        end
        rready = 1'b1;
    endtask

    task automatic burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] br, input bit rnd);
        rnd_rdy = rnd;
        issue(id, addr, len, size, br);
        wait_idle();
        rnd_rdy = 0;
    endtask

    initial begin
        rst_n = 1'b0; rready = 1'b1; arvalid = 2'b00;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        burst(0, 32'h0000_1000, 8'd15, 3'd2, 2'b01, 0);
        burst(0, 32'h0000_4000, 8'd3,  3'd2, 2'b01, 0);
        burst(0, 32'h0000_0020, 8'd2,  3'd2, 2'b00, 0);
        burst(1, 32'h0000_0100, 8'd1,  3'd2, 2'b10, 0);
        burst(1, 32'h0000_2000, 8'd15, 3'd2, 2'b01, 1);
        burst(0, 32'hFFFF_FFF8, 8'd3,  3'd2, 2'b01, 0);
        burst(1, 32'h0000_1003, 8'd2,  3'd2, 2'b01, 0);
        burst(0, 32'h0000_0040, 8'd0,  3'd2, 2'b11, 0);
        burst(1, 32'h0000_0080, 8'd2,  3'd3, 2'b01, 0);
        burst(0, 32'h0000_00C0, 8'd0,  3'd2, 2'b01, 0);

        for (int k = 0; k < 12; k++) begin
            int          r;
            logic [2:0]  sz;
            logic [1:0]  br;
            r  = int'($urandom_range(0, 7));
            br = (r < 4) ? 2'b01 : (r < 6) ? 2'b00 : (r == 6) ? 2'b10 : 2'b11;
            sz = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd2;
            burst(1'($urandom), $urandom, 8'($urandom_range(0, 7)), sz, br, 1);
        end

        // Abort a 16-beat burst after its fifth beat, then confirm a clean restart.
        begin
            int base;
            base = mcount[0];
            issue(0, 32'h0000_8000, 8'd15, 3'd2, 2'b01);
            for (int n = 0; n < 500 && mcount[0] < base + 5; n++) @(posedge clk);
            @(posedge clk); #1 rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            wait_idle();
            burst(1, 32'h0000_9000, 8'd3, 3'd2, 2'b01, 0);
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/gslcd_fb_rd_responder.md
GSLCD_FB_RD_RESPONDER -- requirements
Module: gslcd_fb_rd_responder

Interface
REQ-001 SHALL have parameter C_S_AXI_ID_WIDTH, 1, ID width of AR/R channels.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, 32, araddr width.
REQ-003 SHALL have parameter C_S_AXI_DATA_WIDTH, 32, rdata width (only 32 supported).
REQ-004 SHALL have parameter C_PATTERN_SEED, 32'h0000_0000, XOR mask applied to returned data.
REQ-005 SHALL have parameter C_AR_LATENCY, 1, cycles from AR handshake to first rvalid (range 1-15).
REQ-006 SHALL have parameter C_BEAT_GAP, 0, idle cycles inserted after each accepted beat except the last (range 0-15).
REQ-007 SHALL have port s00_axi_aclk  input  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port s00_axi_aresetn  input  1  asynchronous active-low reset.
REQ-009 SHALL have port s00_axi_arid  input  C_S_AXI_ID_WIDTH  read ID.
REQ-010 SHALL have port s00_axi_araddr  input  C_S_AXI_ADDR_WIDTH  burst start byte address.
REQ-011 SHALL have port s00_axi_arlen  input  8  beats minus one.
REQ-012 SHALL have port s00_axi_arsize  input  3  beat size code.
REQ-013 SHALL have port s00_axi_arburst  input  2  burst type.
REQ-014 SHALL have ports s00_axi_arvalid input 1 / s00_axi_arready output 1  AR handshake.
REQ-015 SHALL have port s00_axi_rid  output  C_S_AXI_ID_WIDTH  echoed arid.
REQ-016 SHALL have port s00_axi_rdata  output  32  beat data.
REQ-017 SHALL have port s00_axi_rresp  output  2  beat response.
REQ-018 SHALL have ports s00_axi_rlast output 1, s00_axi_rvalid output 1, s00_axi_rready input 1  R channel.
REQ-019 SHALL have port beat_count  output  32  total R beats accepted since reset, wraps at 2^32.

Function
REQ-020 SHALL implement FSM IDLE, LAT, BEAT, GAP; exactly one burst outstanding.
REQ-021 IDLE: arready=1; on arvalid&arready latch arid, araddr, arlen, arsize, arburst, load latency counter, go LAT.
REQ-022 LAT: arready=0, rvalid=0; after C_AR_LATENCY cycles in LAT go BEAT (first rvalid C_AR_LATENCY cycles after the handshake edge).
REQ-023 BEAT: rvalid=1; rdata, rresp, rlast, rid SHALL stay stable until rvalid&rready.
REQ-024 On beat accept with rlast=1 go IDLE; else go GAP if C_BEAT_GAP>0, otherwise remain in BEAT with next beat on the following cycle.
REQ-025 GAP: rvalid=0 for exactly C_BEAT_GAP cycles, then BEAT.
REQ-026 rdata SHALL equal current beat byte address XOR C_PATTERN_SEED.
REQ-027 INCR (2'b01): beat address = start + 4*beat index, modulo 2^ADDR_WIDTH (wraps silently).
REQ-028 FIXED (2'b00): every beat uses the start address.
REQ-029 WRAP (2'b10), reserved (2'b11), or arsize!=3'b010: all beats return rresp=2'b10 (SLVERR), rdata=0, correct beat count and rlast.
REQ-030 Otherwise rresp=2'b00; low two address bits SHALL be passed through unmodified in the data pattern.
REQ-031 rlast SHALL assert only on beat index arlen; arlen=0 gives single beat with rlast=1.
REQ-032 beat_count SHALL increment by 1 on every rvalid&rready, including SLVERR beats.
REQ-033 rready held low SHALL stall indefinitely with no state or data change.

Reset
REQ-034 On aresetn low, asynchronously: state IDLE, arready=0, rvalid=0, rlast=0, rresp=0, rdata=0, rid=0, beat_count=0, all counters 0.
REQ-035 arready SHALL assert on the first clock edge after reset deassertion; reset mid-burst SHALL abort the burst with no further beats.

Verification
REQ-036 Defaults, araddr=0x1000, arlen=15, INCR, size 2, rready=1 -> 16 consecutive beats rdata 0x1000..0x103C, rlast on beat 16 only, beat_count=16.
REQ-037 C_AR_LATENCY=3, C_BEAT_GAP=2, arlen=3 -> first rvalid 3 cycles after AR, 2-cycle rvalid gaps, 4 beats total.
REQ-038 FIXED, araddr=0x20, arlen=2, C_PATTERN_SEED=0xFFFF_FFFF -> 3 beats each 0xFFFF_FFDF, rresp=0.
REQ-039 arburst=2'b10, arlen=1, arid=1 -> 2 beats rresp=2'b10, rdata=0, rid=1, rlast on beat 2.
REQ-040 rready toggled randomly during 16-beat burst -> rdata/rlast stable while stalled, no beat lost or repeated.
REQ-041 aresetn pulled low after beat 5 of 16 -> rvalid=0 immediately, beat_count=0, next AR accepted normally.
